// File: rtl/decode_stage_reg_if.sv
// decode_stage_reg_if
//   Bundles the IF->ID inputs, the write-back port, the forwarding-status
//   inputs and the ID/EX register outputs of the decode stage.
//   master : the pipeline around the stage (drives instruction, write-back,
//            EX/MEM destinations; observes hazard and the ID/EX register)
//   slave  : the decode stage itself
interface decode_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] pc_in;
  logic [31:0]       instruction;
  logic              valid_in;
  logic              flush;
  logic [DATA_W-1:0] result_wb;
  logic              write_back;
  logic [3:0]        dest_wb;
  logic [3:0]        status;
  logic              ex_wb_en;
  logic              mem_wb_en;
  logic [3:0]        ex_dest;
  logic [3:0]        mem_dest;

  logic              hazard;
  logic [DATA_W-1:0] pc_out;
  logic [DATA_W-1:0] val_rn;
  logic [DATA_W-1:0] val_rm;
  logic [3:0]        rd;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic [3:0]        exec_cmd;
  logic              wb_enable;
  logic              mem_read;
  logic              mem_write;
  logic              b;
  logic              s;
  logic              imm;
  logic              valid_out;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;

  modport master (
    output pc_in, instruction, valid_in, flush, result_wb, write_back, dest_wb,
           status, ex_wb_en, mem_wb_en, ex_dest, mem_dest,
    input  hazard, pc_out, val_rn, val_rm, rd, src1, src2, exec_cmd, wb_enable,
           mem_read, mem_write, b, s, imm, valid_out, shift_operand, signed_imm_24
  );

  modport slave (
    input  pc_in, instruction, valid_in, flush, result_wb, write_back, dest_wb,
           status, ex_wb_en, mem_wb_en, ex_dest, mem_dest,
    output hazard, pc_out, val_rn, val_rm, rd, src1, src2, exec_cmd, wb_enable,
           mem_read, mem_write, b, s, imm, valid_out, shift_operand, signed_imm_24
  );
endinterface

// File: rtl/decode_stage_reg.sv
// decode_stage_reg
//   ARM-like instruction decode stage with its register file and the ID/EX
//   pipeline register. Decodes mode/opcode/condition, reads Rn/Rm
//   combinationally, raises a combinational load-use style hazard against
//   the EX and MEM destinations, and captures the result (or a bubble) on
//   every rising clk edge.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (clears register file and ID/EX)
//   bus  : decode_stage_reg_if.slave (instruction in, write-back, forwarding
//          status in; hazard and ID/EX register out)
// Configuration
//   DECODE_WB_BYPASS_EN : when defined, a same-cycle write-back to the
//   register being read is forwarded to the read port.
module decode_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input logic               clk,
  input logic               rst,
  decode_stage_reg_if.slave bus
);
  localparam logic [4:0] NREG = 5'(NUM_REGS);

  // Always 16 entries so a 4-bit address indexes cleanly; entries at or
  // above NUM_REGS are never written and read back as 0.
  logic [DATA_W-1:0] rf [16];

  logic [3:0]        cond;
  logic [1:0]        mode;
  logic [3:0]        opcode;
  logic [3:0]        rn_addr;
  logic [3:0]        rm_addr;
  logic              is_alu;
  logic              is_str;
  logic              is_cmp_tst;
  logic              is_mov_mvn;
  logic              two_src;
  logic              cond_ok;
  logic              rn_hit;
  logic              rm_hit;
  logic              bubble;
  logic              wr_ok;
  logic [3:0]        alu_cmd;
  logic              alu_known;
  logic [3:0]        dec_cmd;
  logic              dec_wb;
  logic              dec_mr;
  logic              dec_mw;
  logic              dec_b;
  logic              dec_s;
  logic              dec_imm;
  logic [DATA_W-1:0] rn_data;
  logic [DATA_W-1:0] rm_data;

  assign cond       = bus.instruction[31:28];
  assign mode       = bus.instruction[27:26];
  assign opcode     = bus.instruction[24:21];
  assign is_alu     = (mode == 2'b00);
  assign is_str     = (mode == 2'b01) && !bus.instruction[20];
  assign is_cmp_tst = (opcode == 4'b1010) || (opcode == 4'b1000);
  assign is_mov_mvn = (opcode == 4'b1101) || (opcode == 4'b1111);
  assign rn_addr    = bus.instruction[19:16];
  assign rm_addr    = is_str ? bus.instruction[15:12] : bus.instruction[3:0];
  assign two_src    = is_str || (is_alu && !bus.instruction[25]);
  assign wr_ok      = ({1'b0, bus.dest_wb} < NREG);

  // Condition field against status = {Z,N,C,V}
  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = bus.status[3];
      4'b0001: cond_ok = !bus.status[3];
      4'b0010: cond_ok = bus.status[1];
      4'b0011: cond_ok = !bus.status[1];
      4'b0100: cond_ok = bus.status[2];
      4'b0101: cond_ok = !bus.status[2];
      4'b0110: cond_ok = bus.status[0];
      4'b0111: cond_ok = !bus.status[0];
      4'b1000: cond_ok = bus.status[1] && !bus.status[3];
      4'b1001: cond_ok = !bus.status[1] || bus.status[3];
      4'b1010: cond_ok = (bus.status[2] == bus.status[0]);
      4'b1011: cond_ok = (bus.status[2] != bus.status[0]);
      4'b1100: cond_ok = !bus.status[3] && (bus.status[2] == bus.status[0]);
      4'b1101: cond_ok = bus.status[3] || (bus.status[2] != bus.status[0]);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_known = 1'b1;
    alu_cmd   = 4'b0000;
    case (opcode)
      4'b1101: alu_cmd = 4'b0001;
      4'b1111: alu_cmd = 4'b1001;
      4'b0100: alu_cmd = 4'b0010;
      4'b0101: alu_cmd = 4'b0011;
      4'b0010: alu_cmd = 4'b0100;
      4'b0110: alu_cmd = 4'b0101;
      4'b0000: alu_cmd = 4'b0110;
      4'b1100: alu_cmd = 4'b0111;
      4'b0001: alu_cmd = 4'b1000;
      4'b1010: alu_cmd = 4'b0100;
      4'b1000: alu_cmd = 4'b0110;
      default: alu_known = 1'b0;
    endcase
  end

  always_comb begin
    dec_cmd = 4'b0000;
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    dec_imm = 1'b0;
    if (cond_ok) begin
      case (mode)
        2'b00: begin
          if (alu_known) begin
            dec_cmd = alu_cmd;
            dec_wb  = !is_cmp_tst;
            dec_s   = bus.instruction[20] || is_cmp_tst;
            dec_imm = bus.instruction[25];
          end
        end
        2'b01: begin
          dec_cmd = 4'b0010;
          dec_mr  = bus.instruction[20];
          dec_wb  = bus.instruction[20];
          dec_mw  = !bus.instruction[20];
        end
        2'b10:   dec_b = 1'b1;
        default: ;
      endcase
    end
  end

  // MOV/MVN ignore Rn, so it cannot stall them.
  assign rn_hit = (bus.ex_wb_en && (bus.ex_dest == rn_addr)) ||
                  (bus.mem_wb_en && (bus.mem_dest == rn_addr));
  assign rm_hit = (bus.ex_wb_en && (bus.ex_dest == rm_addr)) ||
                  (bus.mem_wb_en && (bus.mem_dest == rm_addr));
  assign bus.hazard = bus.valid_in &&
                      (((!(is_alu && is_mov_mvn)) && rn_hit) || (two_src && rm_hit));

  assign bubble = bus.flush || bus.hazard || !bus.valid_in;

  always_comb begin
    rn_data = '0;
    rm_data = '0;
    if ({1'b0, rn_addr} < NREG) rn_data = rf[rn_addr];
    if ({1'b0, rm_addr} < NREG) rm_data = rf[rm_addr];
`ifdef DECODE_WB_BYPASS_EN
    if (bus.write_back && wr_ok && (bus.dest_wb == rn_addr)) rn_data = bus.result_wb;
    if (bus.write_back && wr_ok && (bus.dest_wb == rm_addr)) rm_data = bus.result_wb;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (bus.write_back && wr_ok) begin
      rf[bus.dest_wb] <= bus.result_wb;
    end
  end

  // ID/EX register: a bubble clears controls but holds the data fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.pc_out        <= '0;
      bus.val_rn        <= '0;
      bus.val_rm        <= '0;
      bus.rd            <= '0;
      bus.src1          <= '0;
      bus.src2          <= '0;
      bus.shift_operand <= '0;
      bus.signed_imm_24 <= '0;
      bus.exec_cmd      <= '0;
      bus.wb_enable     <= 1'b0;
      bus.mem_read      <= 1'b0;
      bus.mem_write     <= 1'b0;
      bus.b             <= 1'b0;
      bus.s             <= 1'b0;
      bus.imm           <= 1'b0;
      bus.valid_out     <= 1'b0;
    end else if (bubble) begin
      bus.exec_cmd  <= '0;
      bus.wb_enable <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.b         <= 1'b0;
      bus.s         <= 1'b0;
      bus.imm       <= 1'b0;
      bus.valid_out <= 1'b0;
    end else begin
      bus.pc_out        <= bus.pc_in;
      bus.val_rn        <= rn_data;
      bus.val_rm        <= rm_data;
      bus.rd            <= bus.instruction[15:12];
      bus.src1          <= rn_addr;
      bus.src2          <= rm_addr;
      bus.shift_operand <= bus.instruction[11:0];
      bus.signed_imm_24 <= bus.instruction[23:0];
      bus.exec_cmd      <= dec_cmd;
      bus.wb_enable     <= dec_wb;
      bus.mem_read      <= dec_mr;
      bus.mem_write     <= dec_mw;
      bus.b             <= dec_b;
      bus.s             <= dec_s;
      bus.imm           <= dec_imm;
      bus.valid_out     <= cond_ok;
    end
  end
endmodule
